// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes and flag bit positions shared by the condition stage
package cond_pkg;

  // ARM condition field encodings (Instr[31:28])
  localparam logic [3:0] COND_EQ  = 4'h0;
  localparam logic [3:0] COND_NE  = 4'h1;
  localparam logic [3:0] COND_CS  = 4'h2;
  localparam logic [3:0] COND_CC  = 4'h3;
  localparam logic [3:0] COND_MI  = 4'h4;
  localparam logic [3:0] COND_PL  = 4'h5;
  localparam logic [3:0] COND_VS  = 4'h6;
  localparam logic [3:0] COND_VC  = 4'h7;
  localparam logic [3:0] COND_HI  = 4'h8;
  localparam logic [3:0] COND_LS  = 4'h9;
  localparam logic [3:0] COND_GE  = 4'hA;
  localparam logic [3:0] COND_LT  = 4'hB;
  localparam logic [3:0] COND_GT  = 4'hC;
  localparam logic [3:0] COND_LE  = 4'hD;
  localparam logic [3:0] COND_AL  = 4'hE;
  localparam logic [3:0] COND_ALT = 4'hF;

  // bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational evaluation of a condition field against stored flags
//   Cond   in  4  condition field
//   Flags  in  4  stored {N,Z,C,V}
//   CondEx out 1  1 when the instruction should execute
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ:  CondEx = z;
      COND_NE:  CondEx = ~z;
      COND_CS:  CondEx = c;
      COND_CC:  CondEx = ~c;
      COND_MI:  CondEx = n;
      COND_PL:  CondEx = ~n;
      COND_VS:  CondEx = v;
      COND_VC:  CondEx = ~v;
      COND_HI:  CondEx = c & ~z;
      COND_LS:  CondEx = ~c | z;
      COND_GE:  CondEx = (n == v);
      COND_LT:  CondEx = (n != v);
      COND_GT:  CondEx = ~z & (n == v);
      COND_LE:  CondEx = z | (n != v);
      COND_AL:  CondEx = 1'b1;
      // the unused 4'hF encoding behaves as "always"
      COND_ALT: CondEx = 1'b1;
      default:  CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag storage, condition evaluation and gated write enables
//   clk, reset          clock, synchronous active-high reset
//   Cond[3:0]           instruction condition field
//   ALUFlags[3:0]       {N,Z,C,V} from the ALU
//   FlagW[1:0]          [1] updates N,Z  [0] updates C,V
//   PCS, NextPC         conditional PC write, unconditional PC increment
//   RegW, MemW          write requests from the control FSM
//   CondCheck           decode-cycle pulse, feeds the statistics counters
//   PCWrite, RegWrite, MemWrite  gated enables
//   Flags[3:0]          stored {N,Z,C,V}
//   CondEx              condition result against the stored flags
//   ExecCount, SkipCount  statistics counters, present only with COND_STATS_EN
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             CondCheck,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondEx
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
`endif
);

  logic [1:0] flags_nz;
  logic [1:0] flags_cv;
  logic       cond_ex_delayed;
  logic [1:0] flag_write;

  assign Flags = {flags_nz, flags_cv};

  // evaluated against the stored flags only; ALUFlags never bypasses into CondEx
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  assign flag_write = FlagW & {CondEx, CondEx};

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_nz        <= 2'b00;
      flags_cv        <= 2'b00;
      cond_ex_delayed <= 1'b0;
    end else begin
      if (flag_write[1]) flags_nz <= ALUFlags[3:2];
      if (flag_write[0]) flags_cv <= ALUFlags[1:0];
      // decode-cycle result carried into execute/writeback
      cond_ex_delayed <= CondEx;
    end
  end

  assign RegWrite = RegW & cond_ex_delayed;
  assign MemWrite = MemW & cond_ex_delayed;
  assign PCWrite  = (PCS & cond_ex_delayed) | NextPC;

`ifdef COND_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      ExecCount <= '0;
      SkipCount <= '0;
    end else if (CondCheck) begin
      // counters stick at all-ones instead of wrapping
      if (CondEx) begin
        if (ExecCount != '1) ExecCount <= ExecCount + CNT_ONE;
      end else begin
        if (SkipCount != '1) SkipCount <= SkipCount + CNT_ONE;
      end
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
  logic unused_cond_check;
  assign unused_cond_check = CondCheck;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit with a behavioural flag model
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW, CondCheck;
  logic       PCWrite, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
`ifdef COND_STATS_EN
  logic [15:0] ExecCount, SkipCount;
  logic [1:0]  sat_exec, sat_skip;
  logic        sat_pcw, sat_rw, sat_mw, sat_cex;
  logic [3:0]  sat_flags;
`endif

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CondCheck(CondCheck),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
    .CondEx(CondEx)
`ifdef COND_STATS_EN
    , .ExecCount(ExecCount), .SkipCount(SkipCount)
`endif
  );

`ifdef COND_STATS_EN
  cond_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CondCheck(CondCheck),
    .PCWrite(sat_pcw), .RegWrite(sat_rw), .MemWrite(sat_mw), .Flags(sat_flags),
    .CondEx(sat_cex), .ExecCount(sat_exec), .SkipCount(sat_skip)
  );
`endif

  int checks = 0;
  int errors = 0;

  // reference state
  logic [3:0] m_flags;
  logic       m_cexd;
  int         m_exec, m_skip, s_exec, s_skip;

  // conditions come in complementary pairs: bit 0 inverts the base test
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic cex;
    cex = ref_cond(Cond, m_flags);
    chk("condex", {31'b0, CondEx}, {31'b0, cex});
    chk("flags", {28'b0, Flags}, {28'b0, m_flags});
    chk("regwrite", {31'b0, RegWrite}, {31'b0, RegW && m_cexd});
    chk("memwrite", {31'b0, MemWrite}, {31'b0, MemW && m_cexd});
    chk("pcwrite", {31'b0, PCWrite}, {31'b0, (PCS && m_cexd) || NextPC});
`ifdef COND_STATS_EN
    chk("execcount", {16'b0, ExecCount}, m_exec);
    chk("skipcount", {16'b0, SkipCount}, m_skip);
    chk("sat_exec", {30'b0, sat_exec}, s_exec);
    chk("sat_skip", {30'b0, sat_skip}, s_skip);
`endif
  endtask

  task automatic set_in(input logic rst, input logic [3:0] cc, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs, input logic npc,
                        input logic rw, input logic mw, input logic chkp);
    reset = rst; Cond = cc; ALUFlags = alu; FlagW = fw;
    PCS = pcs; NextPC = npc; RegW = rw; MemW = mw; CondCheck = chkp;
    #1;
    model_check();
  endtask

  task automatic tick();
    logic cex;
    @(posedge clk);
    cex = ref_cond(Cond, m_flags);
    if (reset) begin
      m_flags = 4'b0; m_cexd = 1'b0;
      m_exec = 0; m_skip = 0; s_exec = 0; s_skip = 0;
    end else begin
      if (FlagW[1] && cex) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && cex) m_flags[1:0] = ALUFlags[1:0];
      m_cexd = cex;
      if (CondCheck) begin
        if (cex) begin
          m_exec = (m_exec < 65535) ? m_exec + 1 : m_exec;
          s_exec = (s_exec < 3) ? s_exec + 1 : s_exec;
        end else begin
          m_skip = (m_skip < 65535) ? m_skip + 1 : m_skip;
          s_skip = (s_skip < 3) ? s_skip + 1 : s_skip;
        end
      end
    end
    #1;
  endtask

  logic [3:0] sweep_vals [5] = '{4'b0000, 4'b0100, 4'b1001, 4'b0010, 4'b1010};

  initial begin
    m_flags = 4'b0; m_cexd = 1'b0;
    m_exec = 0; m_skip = 0; s_exec = 0; s_skip = 0;
    reset = 1'b1; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0; CondCheck = 0;
    @(negedge clk);

    // reset held for two edges
    set_in(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick();
    set_in(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick();
    set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    chk("rst_flags", {28'b0, Flags}, 32'h0);
    chk("rst_eq", {31'b0, CondEx}, 32'h0);
    chk("rst_regwrite", {31'b0, RegWrite}, 32'h0);
    set_in(0, 4'h1, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    chk("rst_ne", {31'b0, CondEx}, 32'h1);

    // split flag write
    set_in(0, 4'hE, 4'hF, 2'b10, 0, 0, 0, 0, 0); tick();
    chk("split_nz", {28'b0, Flags}, 32'hC);
    set_in(0, 4'hE, 4'h0, 2'b01, 0, 0, 0, 0, 0); tick();
    chk("split_cv0", {28'b0, Flags}, 32'hC);
    set_in(0, 4'hE, 4'h3, 2'b01, 0, 0, 0, 0, 0); tick();
    chk("split_cv1", {28'b0, Flags}, 32'hF);

    // condition sweep over several flag patterns
    foreach (sweep_vals[k]) begin
      set_in(0, 4'hE, sweep_vals[k], 2'b11, 0, 0, 0, 0, 0); tick();
      for (int c = 0; c < 16; c++) begin
        set_in(0, c[3:0], 4'h0, 2'b00, 0, 0, 0, 0, 0);
        if (k == 2 && c == 10) chk("ge_1001", {31'b0, CondEx}, 32'h1);
        if (k == 3 && c == 8)  chk("hi_0010", {31'b0, CondEx}, 32'h1);
      end
    end

    // squashed instruction: EQ with Z clear
    set_in(0, 4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 0); tick();
    set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick();
    set_in(0, 4'h0, 4'hF, 2'b11, 1, 0, 1, 1, 0);
    chk("sq_regwrite", {31'b0, RegWrite}, 32'h0);
    chk("sq_memwrite", {31'b0, MemWrite}, 32'h0);
    chk("sq_pcwrite", {31'b0, PCWrite}, 32'h0);
    set_in(0, 4'h0, 4'hF, 2'b11, 1, 1, 1, 1, 0);
    chk("sq_nextpc", {31'b0, PCWrite}, 32'h1);
    tick();
    chk("sq_flags", {28'b0, Flags}, 32'h0);

    // reset in the middle of an executing instruction
    set_in(0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0); tick();
    set_in(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    chk("mid_regwrite_pre", {31'b0, RegWrite}, 32'h1);
    set_in(1, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 0); tick();
    set_in(0, 4'hE, 4'h0, 2'b00, 1, 0, 1, 1, 0);
    chk("mid_regwrite", {31'b0, RegWrite}, 32'h0);
    chk("mid_flags", {28'b0, Flags}, 32'h0);
    set_in(0, 4'hE, 4'h0, 2'b00, 1, 1, 1, 1, 0);
    chk("mid_pcwrite", {31'b0, PCWrite}, 32'h1);

`ifdef COND_STATS_EN
    set_in(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick();
    repeat (3) begin set_in(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1); tick(); end
    repeat (2) begin set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1); tick(); end
    set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    chk("stat_exec3", {16'b0, ExecCount}, 32'd3);
    chk("stat_skip2", {16'b0, SkipCount}, 32'd2);
    repeat (2) begin set_in(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1); tick(); end
    set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    chk("stat_sat", {30'b0, sat_exec}, 32'd3);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Condition/flags stage directly downstream of the multicycle datapath ALU.
- Holds the architectural NZCV flags, captured from the ALU's 4-bit ALUFlags bus.
- Evaluates the 4-bit ARM condition field against the stored flags.
- Produces the gated write enables (PCWrite, RegWrite, MemWrite) consumed by the multicycle control FSM and datapath.

Parameters:
- CNT_W, 16, width of the statistics counters (only used when COND_STATS_EN is defined).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in the ALU cycle.
- FlagW  in  2  FlagW[1] enables the N,Z update; FlagW[0] enables the C,V update.
- PCS  in  1  instruction writes the PC (branch or R15 destination).
- NextPC  in  1  unconditional PC increment (fetch state).
- RegW  in  1  register-file write request from the FSM.
- MemW  in  1  memory write request from the FSM.
- CondCheck  in  1  1-cycle pulse in the decode state; used by the statistics option only.
- PCWrite  out  1  gated PC enable.
- RegWrite  out  1  gated register-file write enable.
- MemWrite  out  1  gated memory write enable.
- Flags  out  4  current stored {N,Z,C,V}, for debug.
- CondEx  out  1  combinational condition result.

Behaviour:
- One clock. Reset is synchronous and active-high; `reset` is sampled only at the rising edge of `clk`.
- State registers:
  - FlagsNZ[1:0], FlagsCV[1:0]: reset to 0.
  - CondExDelayed: reset to 0.
- CondEx is combinational from Cond and the stored flags (not from ALUFlags):
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C&~Z
  - 9 LS: ~C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: ~Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 1 (treated as always)
- Flag write:
  - FlagWrite[1] = FlagW[1] & CondEx; when 1, FlagsNZ <= ALUFlags[3:2] at the next edge.
  - FlagWrite[0] = FlagW[0] & CondEx; when 1, FlagsCV <= ALUFlags[1:0] at the next edge.
  - The two halves are independent; a half not written holds its value.
- CondExDelayed <= CondEx on every edge, so the decode-cycle result is available in the following execute/writeback states.
- Output enables (combinational, no added latency):
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
  - PCWrite = (PCS & CondExDelayed) | NextPC
- Same-cycle read/write: a flag write in cycle t is visible to CondEx from cycle t+1. There is no bypass of ALUFlags into CondEx.
- Reset mid-instruction:
  - All flags and CondExDelayed return to 0 at that edge.
  - RegWrite and MemWrite are 0 in the cycle after reset.
  - PCWrite follows NextPC only in that cycle.
- Flags output = {FlagsNZ, FlagsCV}; reset value 4'b0000. After reset, EQ evaluates false and NE true.

Optional Feature:
- Macro: COND_STATS_EN.
- Defined:
  - Adds outputs ExecCount[CNT_W-1:0] and SkipCount[CNT_W-1:0], both reset to 0.
  - On a cycle with CondCheck=1: ExecCount increments if CondEx=1, else SkipCount increments.
  - Both counters saturate at all-ones and never wrap.
  - reset has priority over increment.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package cond_pkg:
  - condition code localparams (COND_EQ..COND_AL, 4'hE, 4'hF);
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One natural sub-module, cond_check: purely combinational, Cond + Flags -> CondEx. It is instantiated once.
- The flag registers, delay register, gating and counters stay in cond_unit.

Test Plan:
- Reset: assert reset for 2 cycles.
  - Flags=0000, CondExDelayed=0.
  - Cond=0 gives CondEx=0; Cond=1 gives CondEx=1.
  - RegW=1 gives RegWrite=0.
- Split flag write: Cond=E, ALUFlags=1111, FlagW=10, one edge.
  - Flags=1100.
  - Then FlagW=01 with ALUFlags=0000: Flags=1100 (C,V already 0).
  - Then ALUFlags=0011, FlagW=01: Flags=1111.
- Condition sweep: for each Flags in {0000, 0100, 1001, 0010, 1010}, step Cond 0..F.
  - CondEx matches the table, e.g. Flags=1001, Cond=A (GE) gives 1.
  - Flags=0010, Cond=8 (HI) gives 1.
- Squashed instruction: Flags Z=0, Cond=0 (EQ) in decode, then RegW=1, MemW=1, PCS=1.
  - RegWrite=MemWrite=PCWrite=0 in the following cycle.
  - NextPC=1 forces PCWrite=1.
  - FlagW=11 leaves the flags unchanged.
- Mid-instruction reset: CondExDelayed=1 with RegW=1, then reset asserted for one edge.
  - RegWrite=0 in the next cycle.
  - Flags=0000.
- COND_STATS_EN: 3 CondCheck pulses with CondEx=1 and 2 with CondEx=0 give ExecCount=3, SkipCount=2.
  - With CNT_W=2, 5 exec pulses give ExecCount=3 (saturated).
